// File: rtl/four_bit_odd_parity_generator_if.sv
// four_bit_odd_parity_generator_if: generate/check bus between link logic and the parity block
interface four_bit_odd_parity_generator_if #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic [N-1:0]         data;
    logic                 parity;
    logic [N:0]           parity_data;
    logic                 out_valid;
    logic                 chk_valid;
    logic [N:0]           chk_data;
    logic                 parity_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_clr;

    modport master (
        output in_valid, data, chk_valid, chk_data, err_clr,
        input  parity, parity_data, out_valid, parity_err, err_count
    );

    modport slave (
        input  in_valid, data, chk_valid, chk_data, err_clr,
        output parity, parity_data, out_valid, parity_err, err_count
    );
endinterface

// File: rtl/four_bit_odd_parity_generator.sv
// four_bit_odd_parity_generator: registered odd-parity encoder plus codeword checker with saturating error count
module four_bit_odd_parity_generator #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8
) (
    input logic                             clk,
    input logic                             rst,
    four_bit_odd_parity_generator_if.slave  bus
);
    logic                 r_parity;
    logic [N-1:0]         r_data;
    logic                 r_out_valid;
    logic                 r_parity_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_err;

    assign w_err = bus.chk_valid & ~^bus.chk_data;

    // Reset leaves the codeword at the valid odd encoding of zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity     <= 1'b1;
            r_data       <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_out_valid  <= bus.in_valid;
            r_parity_err <= w_err;
            if (bus.in_valid) begin
                r_parity <= ~^bus.data;
                r_data   <= bus.data;
            end
            if (bus.err_clr)
                r_err_count <= '0;
            else if (w_err && r_err_count != '1)
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.parity      = r_parity;
    assign bus.parity_data = {r_parity, r_data};
    assign bus.out_valid   = r_out_valid;
    assign bus.parity_err  = r_parity_err;
    assign bus.err_count   = r_err_count;
endmodule

// File: tb/tb_four_bit_odd_parity_generator.sv
// tb_four_bit_odd_parity_generator: directed table and sequences for the odd-parity generator/checker
module tb_four_bit_odd_parity_generator;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    four_bit_odd_parity_generator_if #(.N(4), .ERR_CNT_W(8)) b8 ();
    four_bit_odd_parity_generator_if #(.N(4), .ERR_CNT_W(2)) b2 ();

    assign b2.in_valid  = b8.in_valid;
    assign b2.data      = b8.data;
    assign b2.chk_valid = b8.chk_valid;
    assign b2.chk_data  = b8.chk_data;
    assign b2.err_clr   = b8.err_clr;

    four_bit_odd_parity_generator #(.N(4), .ERR_CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    four_bit_odd_parity_generator #(.N(4), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct packed {
        logic [3:0] data;
        logic [4:0] code;
    } vec_t;

    vec_t vecs [16];

    logic [4:0] exp_pd;
    logic       exp_ov;
    logic       exp_err;
    logic [7:0] exp_c8;
    logic [1:0] exp_c2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // One clock with the given inputs; the reference state is advanced and every output compared
    task automatic cyc(input logic r, input logic iv, input logic [3:0] d,
                       input logic cv, input logic [4:0] cd, input logic clr);
        logic e;
        rst          = r;
        b8.in_valid  = iv;
        b8.data      = d;
        b8.chk_valid = cv;
        b8.chk_data  = cd;
        b8.err_clr   = clr;
        @(posedge clk);
        #1;
        if (r) begin
            exp_pd = 5'b10000; exp_ov = 1'b0; exp_err = 1'b0; exp_c8 = '0; exp_c2 = '0;
        end else begin
            e       = cv & ~^cd;
            exp_ov  = iv;
            exp_err = e;
            if (iv) exp_pd = {~^d, d};
            if (clr) begin
                exp_c8 = '0; exp_c2 = '0;
            end else if (e) begin
                if (exp_c8 != 8'hff) exp_c8 = exp_c8 + 1'b1;
                if (exp_c2 != 2'h3)  exp_c2 = exp_c2 + 1'b1;
            end
        end
        check("parity",        32'(b8.parity),      32'(exp_pd[4]));
        check("parity_data",   32'(b8.parity_data), 32'(exp_pd));
        check("out_valid",     32'(b8.out_valid),   32'(exp_ov));
        check("parity_err",    32'(b8.parity_err),  32'(exp_err));
        check("err_count",     32'(b8.err_count),   32'(exp_c8));
        check("err_count_w2",  32'(b2.err_count),   32'(exp_c2));
        check("parity_data_2", 32'(b2.parity_data), 32'(exp_pd));
    endtask

    initial begin
        logic [4:0] cw;
        vecs[0]  = '{4'd0,  5'b10000}; vecs[1]  = '{4'd1,  5'b00001};
        vecs[2]  = '{4'd2,  5'b00010}; vecs[3]  = '{4'd3,  5'b10011};
        vecs[4]  = '{4'd4,  5'b00100}; vecs[5]  = '{4'd5,  5'b10101};
        vecs[6]  = '{4'd6,  5'b10110}; vecs[7]  = '{4'd7,  5'b00111};
        vecs[8]  = '{4'd8,  5'b01000}; vecs[9]  = '{4'd9,  5'b11001};
        vecs[10] = '{4'd10, 5'b11010}; vecs[11] = '{4'd11, 5'b01011};
        vecs[12] = '{4'd12, 5'b11100}; vecs[13] = '{4'd13, 5'b01101};
        vecs[14] = '{4'd14, 5'b01110}; vecs[15] = '{4'd15, 5'b11111};

        // Reset overrides valid inputs, an error and a clear in the same cycle
        cyc(1, 1, 4'd5, 1, 5'b00000, 0);
        cyc(1, 1, 4'd6, 1, 5'b00011, 1);
        check("rst_parity_data", 32'(b8.parity_data), 32'h10);

        foreach (vecs[i]) begin
            cyc(0, 1, vecs[i].data, 0, 5'b0, 0);
            check("table_code", 32'(b8.parity_data), 32'(vecs[i].code));
            check("table_ov",   32'(b8.out_valid),   32'h1);
        end

        cyc(0, 0, 4'd9, 0, 5'b0, 0);
        check("hold_code", 32'(b8.parity_data), 32'h1f);
        cyc(0, 0, 4'd2, 0, 5'b0, 0);
        check("hold_ov", 32'(b8.out_valid), 32'h0);

        cyc(0, 0, 4'd0, 1, 5'b10000, 0);
        check("chk_good", 32'(b8.parity_err), 32'h0);
        cyc(0, 0, 4'd0, 1, 5'b00000, 0);
        check("chk_bad_err", 32'(b8.parity_err), 32'h1);
        check("chk_bad_cnt", 32'(b8.err_count),  32'h1);

        for (int i = 0; i < 5; i++) cyc(0, 0, 4'd0, 1, 5'b00110, 0);
        check("sat_w2",  32'(b2.err_count), 32'h3);
        check("cnt_w8",  32'(b8.err_count), 32'h6);
        cyc(0, 0, 4'd0, 1, 5'b00000, 1);
        check("clr_over_err", 32'(b2.err_count), 32'h0);
        cyc(0, 1, 4'd3, 1, 5'b11000, 0);
        cyc(0, 0, 4'd3, 0, 5'b0, 1);
        check("clr_idle", 32'(b8.err_count), 32'h0);

        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 4'(i), 0, 5'b0, 0);
            cw = b8.parity_data;
            cyc(0, 0, 4'(i), 1, cw, 0);
            check("loop_ok", 32'(b8.parity_err), 32'h0);
            cw[i % 5] = ~cw[i % 5];
            cyc(0, 0, 4'(i), 1, cw, 0);
            check("loop_flip", 32'(b8.parity_err), 32'h1);
        end

        // Both paths active together, then reset mid-stream discards the word
        cyc(0, 1, 4'd7, 1, 5'b00000, 0);
        cyc(1, 1, 4'd7, 1, 5'b00000, 0);
        check("mid_rst_code", 32'(b8.parity_data), 32'h10);
        cyc(0, 0, 4'd7, 0, 5'b0, 0);
        check("post_rst_ov", 32'(b8.out_valid), 32'h0);
        cyc(0, 1, 4'd14, 1, 5'b01110, 0);
        check("post_rst_code", 32'(b8.parity_data), 32'h0e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
